bch_dec_ctrl: RTL
=================

// Module: bch_dec_ctrl
// PURPOSE
//  Top-level sequencer of the multi-code BCH decoder (hard/soft, codes 1/2/3).
//  Accepts a set pulse with mode/code, pulls codeword words via ready, runs
//  syndrome -> key-equation -> Chien stages by start/done handshakes, buffers
//  error locations, then streams them on odata with finish. Sits between the
//  bch top ports and the datapath units.
// PARAMETERS
//  LW         10  location width (max code length 1023)
//  LOC_DEPTH  8   location buffer entries
//  WIW        7   word index width (max 128 words)
// PORTS
//  clk         in   1    clock, rising edge
//  rstn        in   1    async active-low reset
//  set         in   1    start request, sampled 1 cycle
//  mode        in   1    0 hard (1 bit/sample), 1 soft (8-bit LLR/sample)
//  code        in   2    1:n=63  2:n=255  3:n=1023 (0 treated as 1)
//  ready       out  1    request next 64-bit idata word
//  word_vld    out  1    idata valid this cycle (to syndrome unit)
//  word_idx    out  WIW  index of word under word_vld
//  cfg_mode    out  1    latched mode
//  cfg_code    out  2    latched code
//  syn_start   out  1    1-cycle pulse
//  syn_done    in   1    syndromes ready
//  kes_start   out  1    1-cycle pulse
//  kes_done    in   1    locator ready
//  kes_fail    in   1    qualified by kes_done; uncorrectable
//  chs_start   out  1    1-cycle pulse
//  chs_loc_vld in   1    Chien root found
//  chs_loc     in   LW   location, ascending order
//  chs_done    in   1    search complete
//  finish      out  1    odata valid
//  odata       out  LW   error location / sentinel
// BEHAVIOUR
//  Reset: all outputs 0, cfg_code=1, FSM IDLE, counters and buffer cleared.
//  Reset mid-operation aborts immediately; no output is emitted.
//  Words: NW = hard {1,4,16}, soft {8,32,128} for code {1,2,3}.
//  FSM: IDLE -set-> LOAD -> SYN -> KES -> CHS -> EMIT -> IDLE.
//  IDLE: set=1 latches mode/code; LOAD entered next cycle.
//  LOAD: ready=1 for exactly NW consecutive cycles, first cycle after set.
//   word_vld/word_idx = ready/counter delayed 1 cycle (bench drives idata on
//   negedge after ready). syn_start pulses on the cycle with the last word_vld.
//  SYN: wait syn_done; kes_start pulses next cycle. KES: wait kes_done;
//   kes_fail=1 -> skip CHS, go EMIT with fail flag; else chs_start next cycle.
//  CHS: each chs_loc_vld pushes chs_loc; pushes past LOC_DEPTH are dropped and
//   set overflow flag. chs_loc_vld and chs_done in same cycle: location kept.
//  EMIT: one entry per cycle, finish=1, buffer order; count=0, fail or overflow
//   -> single cycle finish=1, odata=10'h3FF. Then IDLE, finish=0, odata=0.
//  Latency set->first finish = 1+NW+1 + syn/kes/chs stage latencies + 1.
//  set outside IDLE ignored; done inputs outside their wait state ignored.
//  Buffer count and flags cleared on IDLE->LOAD.
// STRUCTURE
//  Package bch_pkg: state enum, code constants, NW lookup function,
//  NO_ERR=10'h3FF, LW.
//  One sub-module: bch_loc_buf (LOC_DEPTH x LW FIFO with count/overflow).
//  FSM, word counter and handshake pulses stay in this module.
// TESTING
//  hard code=1, no errors (chs_done, no loc) -> ready 1 cycle, finish 1 cycle, odata=1023.
//  hard code=3, Chien returns 5,200,900 -> ready 16 cycles, finish 3 cycles: 5,200,900.
//  soft code=2 -> ready exactly 32 cycles, word_idx 0..31, syn_start on word 31.
//  kes_fail=1 with kes_done -> no chs_start; finish 1 cycle, odata=1023.
//  9 locations on code=3 -> overflow -> finish 1 cycle, odata=1023.
//  rstn low during LOAD word 5 -> ready=0 at once; next set -> full NW from 0.
//  set pulsed during CHS -> ignored; single emission only.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared types and constants for the BCH decoder sequencer.
// Holds the FSM state encoding and the per-code word count lookup.
package bch_pkg;

    localparam int LW        = 10;
    localparam int LOC_DEPTH = 8;
    localparam int WIW       = 7;

    localparam logic [LW-1:0] NO_ERR = 10'h3FF;

    localparam logic [1:0] CODE_63   = 2'd1;
    localparam logic [1:0] CODE_255  = 2'd2;
    localparam logic [1:0] CODE_1023 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SYN,
        S_KES,
        S_CHS,
        S_EMIT
    } state_t;

    // Number of 64-bit input words for a codeword; soft mode is 8x hard.
    function automatic logic [WIW:0] nw_of(input logic m, input logic [1:0] c);
        logic [WIW:0] n;
        case (c)
            CODE_255:  n = 8'd4;
            CODE_1023: n = 8'd16;
            default:   n = 8'd1;
        endcase
        return m ? (n << 3) : n;
    endfunction

endpackage

// File: rtl/bch_loc_buf.sv
// Error-location FIFO filled by the Chien stage and drained on output.
// Head passes the incoming word through when empty so push+pop can overlap.
module bch_loc_buf
    import bch_pkg::*;
#(
    parameter int DEPTH = LOC_DEPTH,
    parameter int W     = LW,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_ovf
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_count = r_cnt;
    assign o_ovf   = r_ovf;
    assign o_head  = (r_cnt == '0) ? i_data : r_mem[r_rp];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && ((r_cnt != '0) || w_wr);

    // Storage, pointers, occupancy and sticky overflow on dropped pushes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= i_data;
                r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_rd)
                r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
            if (i_push && o_full)
                r_ovf <= 1'b1;
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/bch_dec_ctrl.sv
// Top-level sequencer of the multi-code BCH decoder.
// Loads words, chains syndrome/KES/Chien stages, then streams locations.
module bch_dec_ctrl
    import bch_pkg::*;
#(
    parameter int P_LW        = LW,
    parameter int P_LOC_DEPTH = LOC_DEPTH,
    parameter int P_WIW       = WIW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              set,
    input  logic              mode,
    input  logic [1:0]        code,
    output logic              ready,
    output logic              word_vld,
    output logic [P_WIW-1:0]  word_idx,
    output logic              cfg_mode,
    output logic [1:0]        cfg_code,
    output logic              syn_start,
    input  logic              syn_done,
    output logic              kes_start,
    input  logic              kes_done,
    input  logic              kes_fail,
    output logic              chs_start,
    input  logic              chs_loc_vld,
    input  logic [P_LW-1:0]   chs_loc,
    input  logic              chs_done,
    output logic              finish,
    output logic [P_LW-1:0]   odata
);

    localparam int CW = $clog2(P_LOC_DEPTH + 1);

    state_t           r_state;
    logic [P_WIW-1:0] r_cnt;
    logic             r_sent;
    logic [P_WIW:0]   w_nw;
    logic             w_last;
    logic             w_clr;
    logic             w_push;
    logic             w_pop;
    logic [P_LW-1:0]  w_head;
    logic [CW-1:0]    w_bcnt;
    logic             w_full;
    logic             w_bovf;
    logic             w_ovf_now;
    logic             w_sentinel;

    assign w_nw       = nw_of(cfg_mode, cfg_code);
    assign w_last     = ({1'b0, r_cnt} == (w_nw - 1'b1));
    assign w_clr      = (r_state == S_IDLE) && set;
    assign w_push     = (r_state == S_CHS) && chs_loc_vld;
    assign w_ovf_now  = w_bovf || (w_push && w_full);
    assign w_sentinel = w_ovf_now || ((w_bcnt == '0) && !w_push);
    assign w_pop      = ((r_state == S_CHS) && chs_done && !w_sentinel)
                     || ((r_state == S_EMIT) && !r_sent && (w_bcnt != '0));

    bch_loc_buf #(
        .DEPTH (P_LOC_DEPTH),
        .W     (P_LW)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_data  (chs_loc),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_bcnt),
        .o_full  (w_full),
        .o_ovf   (w_bovf)
    );

    // Sequencer FSM with registered handshakes, word counter and output stream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sent    <= 1'b0;
            ready     <= 1'b0;
            word_vld  <= 1'b0;
            word_idx  <= '0;
            cfg_mode  <= 1'b0;
            cfg_code  <= CODE_63;
            syn_start <= 1'b0;
            kes_start <= 1'b0;
            chs_start <= 1'b0;
            finish    <= 1'b0;
            odata     <= '0;
        end else begin
            word_vld  <= 1'b0;
            syn_start <= 1'b0;
            kes_start <= 1'b0;
            chs_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (set) begin
                        cfg_mode <= mode;
                        cfg_code <= (code == 2'd0) ? CODE_63 : code;
                        r_cnt    <= '0;
                        r_sent   <= 1'b0;
                        ready    <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    word_vld <= 1'b1;
                    word_idx <= r_cnt;
                    if (w_last) begin
                        ready     <= 1'b0;
                        syn_start <= 1'b1;
                        r_state   <= S_SYN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SYN: begin
                    if (syn_done) begin
                        kes_start <= 1'b1;
                        r_state   <= S_KES;
                    end
                end
                S_KES: begin
                    if (kes_done) begin
                        if (kes_fail) begin
                            r_sent  <= 1'b1;
                            finish  <= 1'b1;
                            odata   <= NO_ERR;
                            r_state <= S_EMIT;
                        end else begin
                            chs_start <= 1'b1;
                            r_state   <= S_CHS;
                        end
                    end
                end
                S_CHS: begin
                    if (chs_done) begin
                        r_sent  <= w_sentinel;
                        finish  <= 1'b1;
                        odata   <= w_sentinel ? NO_ERR : w_head;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (!r_sent && (w_bcnt != '0)) begin
                        finish <= 1'b1;
                        odata  <= w_head;
                    end else begin
                        finish  <= 1'b0;
                        odata   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
